// File: rtl/program_loader.sv
// Boot-stage loader: buffers a host header/instruction/data stream segment by segment
// and replays each segment as a gapless write burst while holding the processor in reset.
module program_loader #(
    parameter int DEPTH     = 64,
    parameter int AW        = 6,
    parameter int MEM_WORDS = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        proc_rst,
    output logic        inst_load,
    output logic        data_load,
    output logic [31:0] data,
    output logic        busy,
    output logic        load_done,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE, HDR, FILL_I, RST_I, LOAD_I, FILL_D, RST_D, LOAD_D, RUN, ERR
    } state_t;

    localparam logic [15:0] DEPTH_LIM = 16'(DEPTH);
    localparam logic [15:0] MEM_LIM   = 16'(MEM_WORDS);

    state_t        state;
    state_t        state_next;
    logic [15:0]   n_i;
    logic [15:0]   n_d;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          accept;
    logic          hdr_accept;
    logic          push;
    logic          pop;
    logic [15:0]   fill_level;

    assign accept     = s_valid && s_ready;
    assign hdr_accept = accept && (state == IDLE || state == RUN);
    assign push       = accept && (state == FILL_I || state == FILL_D);
    assign fill_level = 16'(count) + 16'(push);

    // A LOAD state lasts until the FIFO drains, so its length equals the segment length.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE, RUN: begin
                if (hdr_accept) state_next = HDR;
            end
            HDR: begin
                if (n_i > DEPTH_LIM || n_d > DEPTH_LIM || n_i > MEM_LIM) state_next = ERR;
                else if (n_i != 16'd0)                                   state_next = FILL_I;
                else if (n_d != 16'd0)                                   state_next = FILL_D;
                else                                                     state_next = RUN;
            end
            FILL_I: begin
                if (fill_level == n_i) state_next = RST_I;
            end
            FILL_D: begin
                if (fill_level == n_d) state_next = RST_D;
            end
            RST_I: begin
                pop        = 1'b1;
                state_next = LOAD_I;
            end
            RST_D: begin
                pop        = 1'b1;
                state_next = LOAD_D;
            end
            LOAD_I: begin
                if (count != '0)        pop = 1'b1;
                else if (n_d != 16'd0)  state_next = FILL_D;
                else                    state_next = RUN;
            end
            LOAD_D: begin
                if (count != '0) pop = 1'b1;
                else             state_next = RUN;
            end
            ERR:     state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n_i       <= '0;
            n_d       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data      <= '0;
            s_ready   <= 1'b0;
            proc_rst  <= 1'b1;
            inst_load <= 1'b0;
            data_load <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_next;
            if (hdr_accept) begin
                n_i <= s_data[15:0];
                n_d <= s_data[31:16];
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                count  <= count + (AW+1)'(1);
            end else if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                count  <= count - (AW+1)'(1);
                data   <= mem[rd_ptr];
            end
            s_ready   <= (state_next == IDLE)   || (state_next == RUN) ||
                         (state_next == FILL_I) || (state_next == FILL_D);
            proc_rst  <= (state_next != RUN);
            inst_load <= (state_next == LOAD_I);
            data_load <= (state_next == LOAD_D);
            busy      <= (state_next != IDLE) && (state_next != RUN) && (state_next != ERR);
            load_done <= (state_next == RUN);
            err       <= (state_next == ERR);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: loads segments through the host port and checks
// the replayed bursts, status outputs, error handling and mid-load reset.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        proc_rst;
    logic        inst_load;
    logic        data_load;
    logic [31:0] data;
    logic        busy;
    logic        load_done;
    logic        err;

    int check_count = 0;
    int error_count = 0;

    logic [31:0] inst_seen[$];
    logic [31:0] data_seen[$];
    int          inst_bursts = 0;
    int          data_bursts = 0;
    int          both_high   = 0;
    logic        prev_inst   = 1'b0;
    logic        prev_data   = 1'b0;

    always #5 clk = ~clk;

    program_loader dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .proc_rst(proc_rst), .inst_load(inst_load), .data_load(data_load), .data(data),
        .busy(busy), .load_done(load_done), .err(err)
    );

    // Record every strobed word and count separate bursts so gaps become visible.
    always @(negedge clk) begin
        if (inst_load) begin
            inst_seen.push_back(data);
            if (!prev_inst) inst_bursts <= inst_bursts + 1;
        end
        if (data_load) begin
            data_seen.push_back(data);
            if (!prev_data) data_bursts <= data_bursts + 1;
        end
        if (inst_load && data_load) both_high <= both_high + 1;
        prev_inst <= inst_load;
        prev_data <= data_load;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] instWord(input logic [7:0] id, input int k);
        return {8'hA0, id, 16'(k)};
    endfunction

    function automatic logic [31:0] dataWord(input logic [7:0] id, input int k);
        return {8'hD0, id, 16'(k)};
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the word transferred.
    task automatic sendWord(input logic [31:0] w);
        int t = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!s_ready) checkOutput("s_ready_timeout", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int t = 0;
        while (!load_done && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        checkOutput(tag, 32'(load_done), 32'd1);
    endtask

    task automatic applyStimulus(input logic [31:0] hdr, input int gap_at, input logic [7:0] id);
        int ni  = int'(hdr[15:0]);
        int nd  = int'(hdr[31:16]);
        int ib  = inst_seen.size();
        int db  = data_seen.size();
        int ibu = inst_bursts;
        int dbu = data_bursts;
        sendWord(hdr);
        checkOutput("hdr_busy", 32'(busy), 32'd1);
        checkOutput("hdr_proc_rst", 32'(proc_rst), 32'd1);
        checkOutput("hdr_load_done", 32'(load_done), 32'd0);
        for (int k = 0; k < ni; k++) begin
            if (k == gap_at) repeat (5) @(posedge clk);
            if (k == gap_at) #1;
            sendWord(instWord(id, k));
        end
        for (int k = 0; k < nd; k++) sendWord(dataWord(id, k));
        waitDone("load_done");
        checkOutput("run_proc_rst", 32'(proc_rst), 32'd0);
        checkOutput("run_busy", 32'(busy), 32'd0);
        checkOutput("run_s_ready", 32'(s_ready), 32'd1);
        checkOutput("run_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        checkOutput("inst_len", 32'(inst_seen.size() - ib), 32'(ni));
        checkOutput("data_len", 32'(data_seen.size() - db), 32'(nd));
        checkOutput("inst_bursts", 32'(inst_bursts - ibu), (ni != 0) ? 32'd1 : 32'd0);
        checkOutput("data_bursts", 32'(data_bursts - dbu), (nd != 0) ? 32'd1 : 32'd0);
        for (int k = 0; k < ni; k++)
            if (ib + k < inst_seen.size()) checkOutput("inst_word", inst_seen[ib + k], instWord(id, k));
        for (int k = 0; k < nd; k++)
            if (db + k < data_seen.size()) checkOutput("data_word", data_seen[db + k], dataWord(id, k));
    endtask

    task automatic doReset();
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int t;
        int isz;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_proc_rst", 32'(proc_rst), 32'd1);
        checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_load_done", 32'(load_done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_strobes", {30'd0, inst_load, data_load}, 32'd0);
        checkOutput("rst_data", data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_s_ready", 32'(s_ready), 32'd1);

        $display("[TB] basic load 3 inst + 2 data");
        applyStimulus(32'h0002_0003, -1, 8'h01);
        $display("[TB] host gap during FILL_I");
        applyStimulus(32'h0001_0004, 2, 8'h02);
        $display("[TB] reload from RUN with data only");
        applyStimulus(32'h0001_0000, -1, 8'h03);
        $display("[TB] full-depth segment");
        applyStimulus(32'h0000_0040, -1, 8'h04);
        $display("[TB] empty header");
        applyStimulus(32'h0000_0000, -1, 8'h05);

        $display("[TB] oversize instruction count");
        sendWord(32'h0000_0041);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("err_flag", 32'(err), 32'd1);
        checkOutput("err_proc_rst", 32'(proc_rst), 32'd1);
        checkOutput("err_s_ready", 32'(s_ready), 32'd0);
        checkOutput("err_busy", 32'(busy), 32'd0);
        isz = inst_seen.size();
        s_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s_data = instWord(8'h06, k);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("err_ignored", 32'(inst_seen.size() - isz), 32'd0);
        checkOutput("err_sticky", 32'(err), 32'd1);
        doReset();
        checkOutput("err_cleared", 32'(err), 32'd0);

        $display("[TB] oversize data count");
        sendWord(32'h0041_0000);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("err_nd_flag", 32'(err), 32'd1);
        doReset();

        $display("[TB] reset during LOAD_I");
        sendWord(32'h0000_0004);
        for (int k = 0; k < 4; k++) sendWord(instWord(8'h07, k));
        t = 0;
        while (!inst_load && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        checkOutput("abort_reached_load", 32'(inst_load), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_proc_rst", 32'(proc_rst), 32'd1);
        checkOutput("abort_inst_load", 32'(inst_load), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_s_ready", 32'(s_ready), 32'd0);
        checkOutput("abort_data", data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(32'h0001_0002, -1, 8'h08);

        checkOutput("both_strobes", 32'(both_high), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
